cursor_ctrl: RTL



---
 rtl/cursor_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/cursor_ctrl.sv
// cursor_ctrl: debounced push-button cursor stepping on a 32x32 cell grid.
// Ports: clk, reset_n, btn_{up,down,left,right,sel} in; cell_col/row,
// top_left_x/y, sel_pulse, moved out.
module cursor_ctrl #(
  parameter int TICK_DIV     = 100000,
  parameter int DB_TICKS     = 10,
  parameter int REPEAT_DELAY = 400,
  parameter int REPEAT_RATE  = 100,
  parameter int GRID_X0      = 0,
  parameter int GRID_Y0      = 0,
  parameter int NCOL         = 20,
  parameter int NROW         = 15,
  parameter int INIT_COL     = 0,
  parameter int INIT_ROW     = 0,
  parameter int WRAP         = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  output logic [4:0] cell_col,
  output logic [3:0] cell_row,
  output logic [9:0] top_left_x,
  output logic [9:0] top_left_y,
  output logic       sel_pulse,
  output logic       moved
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DB_TICKS + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int RW = $clog2(RMAX + 1);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_TICKS - 1);
  localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);
  localparam logic [4:0]    COL_MAX   = 5'(NCOL - 1);
  localparam logic [3:0]    ROW_MAX   = 4'(NROW - 1);

  typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;
  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

  // bit order: {sel, right, left, down, up}
  logic [4:0]    raw, sync1, sync2, db, flip;
  logic [3:0]    dirs;
  logic [DW-1:0] db_cnt [5];
  logic [TW-1:0] tick_cnt;
  logic          tick;

  state_t        state, state_n;
  dir_t          dir, dir_n, sdir;
  logic [RW-1:0] rpt_cnt, rpt_n;
  logic          step;
  logic [4:0]    col_n;
  logic [3:0]    row_n;

  assign raw  = {btn_sel, btn_right, btn_left, btn_down, btn_up};
  assign dirs = db[3:0];
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  // flip fires on the tick that completes DB_TICKS of disagreement
  always_comb begin
    flip = '0;
    for (int i = 0; i < 5; i++)
      flip[i] = tick && (sync2[i] != db[i]) && (db_cnt[i] == DB_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (flip[i]) begin
          db[i]     <= ~db[i];
          db_cnt[i] <= '0;
        end else if (tick) begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sel_pulse <= 1'b0;
    else sel_pulse <= flip[4] & ~db[4];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      dir     <= D_UP;
      rpt_cnt <= '0;
    end else begin
      state   <= state_n;
      dir     <= dir_n;
      rpt_cnt <= rpt_n;
    end
  end

  always_comb begin
    state_n = state;
    dir_n   = dir;
    rpt_n   = rpt_cnt;
    step    = 1'b0;
    sdir    = dir;
    unique case (state)
      IDLE: begin
        if (|dirs) begin
          if (dirs[0]) sdir = D_UP;
          else if (dirs[1]) sdir = D_DOWN;
          else if (dirs[2]) sdir = D_LEFT;
          else sdir = D_RIGHT;
          step    = 1'b1;
          dir_n   = sdir;
          rpt_n   = '0;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (!dirs[dir]) begin
          state_n = IDLE;
        end else if (tick) begin
          if (rpt_cnt == DLY_LAST) begin
            step    = 1'b1;
            rpt_n   = '0;
            state_n = RPT;
          end else begin
            rpt_n = rpt_cnt + 1'b1;
          end
        end
      end
      RPT: begin
        if (!dirs[dir]) begin
          state_n = IDLE;
        end else if (tick) begin
          if (rpt_cnt == RATE_LAST) begin
            step  = 1'b1;
            rpt_n = '0;
          end else begin
            rpt_n = rpt_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // edge handling: clamp keeps the cell, wrap jumps to the far edge
  always_comb begin
    col_n = cell_col;
    row_n = cell_row;
    unique case (sdir)
      D_UP: begin
        if (cell_row != '0) row_n = cell_row - 1'b1;
        else if (WRAP != 0) row_n = ROW_MAX;
      end
      D_DOWN: begin
        if (cell_row != ROW_MAX) row_n = cell_row + 1'b1;
        else if (WRAP != 0) row_n = '0;
      end
      D_LEFT: begin
        if (cell_col != '0) col_n = cell_col - 1'b1;
        else if (WRAP != 0) col_n = COL_MAX;
      end
      D_RIGHT: begin
        if (cell_col != COL_MAX) col_n = cell_col + 1'b1;
        else if (WRAP != 0) col_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cell_col <= 5'(INIT_COL);
      cell_row <= 4'(INIT_ROW);
      moved    <= 1'b0;
    end else begin
      moved <= step && ((col_n != cell_col) || (row_n != cell_row));
      if (step) begin
        cell_col <= col_n;
        cell_row <= row_n;
      end
    end
  end

  assign top_left_x = 10'(GRID_X0) + {cell_col, 5'b0};
  assign top_left_y = 10'(GRID_Y0) + {1'b0, cell_row, 5'b0};

endmodule
